// File: rtl/butterfly_stage.sv
// -----------------------------------------------------------------------------
// butterfly_stage
//
// Radix-2 butterfly over a block of 2*DEPTH beats, NUM complex lanes per beat.
// The first half of each block (operand a) is written into a DEPTH x NUM
// buffer. Each beat of the second half (operand b) is paired lane-by-lane
// with the buffered beat of the same index, producing a+b and a-b.
// Optional divide-by-2 with round-half-up, selected once per block.
//
// Parameters
//   IN_WIDTH  : signed input width per I/Q component
//   OUT_WIDTH : signed output width (>= IN_WIDTH+1)
//   NUM       : parallel lanes per beat
//   DATA      : half-block size in samples (multiple of NUM)
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   clear     : synchronous flush of the block in progress (wins over valid_in)
//   scale_en  : divide-by-2 request, sampled on the first beat of a block
//   valid_in  : input beat qualifier
//   din_i/q   : NUM input lanes, IN_WIDTH signed each
//   do1_re/im : NUM sum lanes (a+b), OUT_WIDTH signed each
//   do2_re/im : NUM difference lanes (a-b), OUT_WIDTH signed each
//   valid_out : output beat qualifier, one cycle after each accepted b beat
//   out_last  : marks the final output beat of a block
//   busy      : a block is partially received
// -----------------------------------------------------------------------------
module butterfly_stage #(
  parameter int IN_WIDTH  = 14,
  parameter int OUT_WIDTH = 15,
  parameter int NUM       = 16,
  parameter int DATA      = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             scale_en,
  input  logic                             valid_in,
  input  logic [NUM-1:0][IN_WIDTH-1:0]     din_i,
  input  logic [NUM-1:0][IN_WIDTH-1:0]     din_q,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do1_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do1_im,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do2_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do2_im,
  output logic                             valid_out,
  output logic                             out_last,
  output logic                             busy
);

  localparam int DEPTH = DATA / NUM;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = IN_WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic signed [SUM_W-1:0] RND_ONE = {{(SUM_W-1){1'b0}}, 1'b1};

  if (OUT_WIDTH < IN_WIDTH + 1) begin : g_bad_out_width
    $error("butterfly_stage: OUT_WIDTH must be at least IN_WIDTH+1");
  end
  if ((DATA % NUM) != 0 || DATA < NUM) begin : g_bad_data
    $error("butterfly_stage: DATA must be a non-zero multiple of NUM");
  end

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  // Sign-extend one input component into the sum/difference width.
  function automatic logic signed [SUM_W-1:0] sext_in(input logic [IN_WIDTH-1:0] x);
    return {{2{x[IN_WIDTH-1]}}, x};
  endfunction

  // Optional divide-by-2, round half up: (x + 1) >>> 1. Without scaling the
  // value is already exact in IN_WIDTH+1 bits; either way the result is
  // sign-extended to OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] round_fold(input logic signed [SUM_W-1:0] x,
                                                      input logic                    scale);
    logic signed [SUM_W-1:0] r;
    if (scale) begin
      r = (x + RND_ONE) >>> 1;
    end else begin
      r = x;
    end
    return OUT_WIDTH'(r);
  endfunction

  state_t                           state_p0;
  logic [CNT_W-1:0]                 cnt_p0;
  logic                             scale_p0;
  logic                             accept_p0;
  logic                             pair_beat_p0;
  logic [NUM-1:0][IN_WIDTH-1:0]     buf_i [DEPTH];
  logic [NUM-1:0][IN_WIDTH-1:0]     buf_q [DEPTH];
  logic [NUM-1:0][IN_WIDTH-1:0]     a_i_p0;
  logic [NUM-1:0][IN_WIDTH-1:0]     a_q_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0]    s_re_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0]    s_im_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0]    d_re_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0]    d_im_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0]    do1_re_p1;
  logic [NUM-1:0][OUT_WIDTH-1:0]    do1_im_p1;
  logic [NUM-1:0][OUT_WIDTH-1:0]    do2_re_p1;
  logic [NUM-1:0][OUT_WIDTH-1:0]    do2_im_p1;
  logic                             vld_p1;
  logic                             last_p1;

  // ---- stage p0: beat acceptance, buffer, butterfly arithmetic ----
  // clear dominates: a beat presented together with clear is dropped.
  assign accept_p0    = valid_in & ~clear;
  assign pair_beat_p0 = accept_p0 & (state_p0 == PAIR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= FILL;
      cnt_p0   <= '0;
      scale_p0 <= 1'b0;
    end else if (clear) begin
      state_p0 <= FILL;
      cnt_p0   <= '0;
    end else if (valid_in) begin
      // The scale choice is latched only on the first beat of a block.
      if (state_p0 == FILL && cnt_p0 == '0) begin
        scale_p0 <= scale_en;
      end
      if (cnt_p0 == LAST_IDX) begin
        cnt_p0   <= '0;
        state_p0 <= (state_p0 == FILL) ? PAIR : FILL;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Operand-a storage. Entry k of the next block is written only after the
  // PAIR beat k of the current block has read it, so back-to-back blocks
  // never overwrite an unread entry. No reset: every entry is written in
  // FILL before PAIR reads it.
  always_ff @(posedge clk) begin
    if (accept_p0 && state_p0 == FILL) begin
      buf_i[cnt_p0] <= din_i;
      buf_q[cnt_p0] <= din_q;
    end
  end

  assign a_i_p0 = buf_i[cnt_p0];
  assign a_q_p0 = buf_q[cnt_p0];

  always_comb begin
    s_re_p0 = '0;
    s_im_p0 = '0;
    d_re_p0 = '0;
    d_im_p0 = '0;
    for (int j = 0; j < NUM; j++) begin
      s_re_p0[j] = round_fold(sext_in(a_i_p0[j]) + sext_in(din_i[j]), scale_p0);
      s_im_p0[j] = round_fold(sext_in(a_q_p0[j]) + sext_in(din_q[j]), scale_p0);
      d_re_p0[j] = round_fold(sext_in(a_i_p0[j]) - sext_in(din_i[j]), scale_p0);
      d_im_p0[j] = round_fold(sext_in(a_q_p0[j]) - sext_in(din_q[j]), scale_p0);
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= pair_beat_p0;
      last_p1 <= pair_beat_p0 & (cnt_p0 == LAST_IDX);
    end
  end

  // Results update only on a PAIR beat and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do1_re_p1 <= '0;
      do1_im_p1 <= '0;
      do2_re_p1 <= '0;
      do2_im_p1 <= '0;
    end else if (pair_beat_p0) begin
      do1_re_p1 <= s_re_p0;
      do1_im_p1 <= s_im_p0;
      do2_re_p1 <= d_re_p0;
      do2_im_p1 <= d_im_p0;
    end
  end

  assign do1_re    = do1_re_p1;
  assign do1_im    = do1_im_p1;
  assign do2_re    = do2_re_p1;
  assign do2_im    = do2_im_p1;
  assign valid_out = vld_p1;
  assign out_last  = last_p1;
  assign busy      = (state_p0 == PAIR) || (cnt_p0 != '0);

endmodule

// File: doc/butterfly_stage.md
BUTTERFLY_STAGE -- requirements
Module: butterfly_stage

Interface
Parameters (name, default, meaning):
REQ-001 IN_WIDTH, 14, signed input sample width per I/Q component.
REQ-002 OUT_WIDTH, 15, signed output width; SHALL be at least IN_WIDTH+1 (elaboration-time assertion).
REQ-003 NUM, 16, parallel lanes per beat.
REQ-004 DATA, 128, half-block size in samples; DEPTH = DATA/NUM beats per half; DATA SHALL be a multiple of NUM.

Ports (name, direction, width, meaning):
REQ-005 clk, in, 1, single clock, rising edge.
REQ-006 rst, in, 1, asynchronous active-high reset.
REQ-007 clear, in, 1, synchronous flush: abandons the block in progress.
REQ-008 scale_en, in, 1, divide-by-2 with rounding, applied to whole block.
REQ-009 valid_in, in, 1, input beat qualifier.
REQ-010 din_i / din_q, in, NUM x IN_WIDTH signed, input lanes.
REQ-011 do1_re / do1_im, out, NUM x OUT_WIDTH signed, sum outputs (a+b).
REQ-012 do2_re / do2_im, out, NUM x OUT_WIDTH signed, difference outputs (a-b).
REQ-013 valid_out, out, 1, output beat qualifier.
REQ-014 out_last, out, 1, high with the final valid_out beat of each block.
REQ-015 busy, out, 1, high while a block is partially received.

Function
REQ-016 Block = 2*DEPTH accepted beats; beat counter advances only on valid_in=1; bubbles (valid_in=0) anywhere SHALL be tolerated with no data loss.
REQ-017 FSM states FILL and PAIR; FILL stores beats 0..DEPTH-1 into a DEPTH x NUM buffer (operand a); FILL->PAIR on accepted beat DEPTH-1.
REQ-018 In PAIR, accepted beat k (k = 0..DEPTH-1 within the half) is operand b; it SHALL pair lane-by-lane with stored beat k; PAIR->FILL on accepted beat DEPTH-1.
REQ-019 Blocks SHALL run back-to-back: a FILL beat accepted the cycle after PAIR ends begins a new block with no gap; a buffer write SHALL never corrupt an entry not yet read.
REQ-020 Unscaled: do1 = a+b, do2 = a-b, computed at IN_WIDTH+1 bits, sign-extended to OUT_WIDTH; exact, no overflow possible.
REQ-021 Scaled: result = (x + 1) >>> 1 on the IN_WIDTH+2-bit value (round half up), sign-extended to OUT_WIDTH.
REQ-022 scale_en SHALL be sampled on accepted FILL beat 0 and held for the whole block; changes mid-block SHALL be ignored.
REQ-023 Latency: output registered; valid_out SHALL assert exactly 1 cycle after each accepted PAIR beat; no output for FILL beats.
REQ-024 out_last SHALL accompany the output of PAIR beat DEPTH-1 only.
REQ-025 Outputs SHALL hold their last value while valid_out=0.
REQ-026 busy = 1 from accepted FILL beat 0 until the cycle after the last PAIR beat is accepted (i.e. while FILL count>0 or state=PAIR).
REQ-027 clear SHALL return FSM to FILL, count to 0, force valid_out/out_last to 0 next cycle; clear with valid_in in the same cycle: clear wins, the beat is discarded.
REQ-028 Buffer contents need no reset; they are never read before being written within a block.

Reset
REQ-029 rst asserted SHALL immediately force state FILL, count 0, held scale 0, valid_out 0, out_last 0, busy 0, all do* 0.
REQ-030 rst asserted mid-block SHALL discard the partial block; the first beat accepted after release is FILL beat 0.

Verification
REQ-031 Defaults; all lanes a=100+j0 for beats 0..7, b=30 for beats 8..15, scale_en=0 -> 8 valid_out beats, do1_re=130, do2_re=70 all lanes; out_last on 8th; first valid_out 1 cycle after beat 8.
REQ-032 a=101, b=30, scale_en=1 at beat 0, toggled to 0 at beat 10 -> do1=66, do2=36 on all 8 output beats.
REQ-033 Extremes a=b=-8192 (re and im) -> unscaled do1=-16384, do2=0; a=8191, b=-8192 -> do2=16383; scaled a=b=-8192 -> do1=-8192.
REQ-034 Random bubbles (valid_in 50% duty) over two back-to-back blocks with ramp data -> outputs match golden model in order, 16 output beats total, exactly 2 out_last pulses.
REQ-035 rst at FILL beat 5, then a full block -> no valid_out from the aborted block; new block output correct.
REQ-036 clear together with valid_in at PAIR beat 3 -> that beat discarded, valid_out 0 next cycle, busy 0, following block correct.
